// File: rtl/matrix_pkg.sv
// Shared constants and types for the matrix operand loader: ALU opcode map,
// element/matrix geometry defaults and the loader FSM state encoding.
package matrix_pkg;

  localparam int ELEM_W_DEF = 16;
  localparam int DIM_DEF    = 4;
  localparam int MAT_W_DEF  = DIM_DEF * DIM_DEF * ELEM_W_DEF;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_MULT  = 4'h1;
  localparam logic [3:0] OP_SCALE = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h4;
  localparam logic [3:0] OP_TRANS = 4'h5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_A  = 2'd1,
    LOAD_B  = 2'd2,
    PRESENT = 2'd3
  } state_e;

  // Single-operand ops present A alone; everything else needs a B matrix.
  function automatic logic skips_b(input logic [3:0] op);
    return (op == OP_TRANS);
  endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// Opcode, element and operand-set handshake bundle between a producer
// (master) and the matrix loader (slave).
interface matrix_loader_if
  import matrix_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int DIM    = DIM_DEF
);
  localparam int MAT_W = DIM * DIM * ELEM_W;

  logic              op_valid_i;
  logic [3:0]        op_i;
  logic              op_ready_o;
  logic              elem_valid_i;
  logic [ELEM_W-1:0] elem_i;
  logic              elem_ready_o;
  logic              mat_valid_o;
  logic              mat_ready_i;
  logic [MAT_W-1:0]  matrix_a_o;
  logic [MAT_W-1:0]  matrix_b_o;
  logic [3:0]        opcode_o;

  modport master (
    output op_valid_i, op_i, elem_valid_i, elem_i, mat_ready_i,
    input  op_ready_o, elem_ready_o, mat_valid_o, matrix_a_o, matrix_b_o, opcode_o
  );

  modport slave (
    input  op_valid_i, op_i, elem_valid_i, elem_i, mat_ready_i,
    output op_ready_o, elem_ready_o, mat_valid_o, matrix_a_o, matrix_b_o, opcode_o
  );

endinterface

// File: rtl/matrix_shift_fill.sv
// Indexed element write register holding one DIM x DIM matrix, row-major,
// with synchronous clear and an optional write-to-all-slots broadcast.
module matrix_shift_fill
  import matrix_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int DIM    = DIM_DEF
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  clr_i,
  input  logic                                  wr_en_i,
  input  logic                                  bcast_i,
  input  logic [$clog2(DIM*DIM)-1:0]            idx_i,
  input  logic [ELEM_W-1:0]                     data_i,
  output logic [DIM*DIM*ELEM_W-1:0]             mat_o
);
  localparam int N_ELEM = DIM * DIM;
  localparam int MAT_W  = N_ELEM * ELEM_W;

  logic [MAT_W-1:0] mat_q;
  logic [MAT_W-1:0] mat_d;

  // Next matrix contents: clear wins over a write, broadcast fills every slot.
  always_comb begin
    mat_d = mat_q;
    if (clr_i) begin
      mat_d = {MAT_W{1'b0}};
    end else if (wr_en_i) begin
      if (bcast_i) begin
        for (int i = 0; i < N_ELEM; i++) begin
          mat_d[i*ELEM_W +: ELEM_W] = data_i;
        end
      end else begin
        mat_d[idx_i*ELEM_W +: ELEM_W] = data_i;
      end
    end else begin
      mat_d = mat_q;
    end
  end

  // Matrix storage.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mat_q <= {MAT_W{1'b0}};
    end else begin
      mat_q <= mat_d;
    end
  end

  assign mat_o = mat_q;

endmodule

// File: rtl/matrix_loader.sv
// Collects an opcode and up to two row-major operand matrices, then presents
// them to the ALU. Define MLOAD_SCALAR_BCAST_EN to load B for op 2 as one broadcast scalar.
module matrix_loader
  import matrix_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int DIM    = DIM_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  matrix_loader_if.slave bus
);
  localparam int N_ELEM = DIM * DIM;
  localparam int CNT_W  = $clog2(N_ELEM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ELEM - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       opcode_q, opcode_d;
  logic             mat_valid_q, mat_valid_d;
  logic             op_ready_q, op_ready_d;
  logic             elem_ready_q, elem_ready_d;

  logic op_hs_s, elem_hs_s, wr_a_s, wr_b_s, clr_b_s, bcast_s, last_s;

  assign op_hs_s   = bus.op_valid_i & op_ready_q;
  assign elem_hs_s = bus.elem_valid_i & elem_ready_q;

`ifdef MLOAD_SCALAR_BCAST_EN
  assign bcast_s = (state_q == LOAD_B) && (opcode_q == OP_SCALE);
`else
  assign bcast_s = 1'b0;
`endif

  // A broadcast B is complete after its single element.
  assign last_s = (cnt_q == CNT_LAST) | bcast_s;

  // Next-state and datapath control; flush overrides any handshake this cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    opcode_d    = opcode_q;
    mat_valid_d = mat_valid_q;
    wr_a_s      = 1'b0;
    wr_b_s      = 1'b0;
    clr_b_s     = 1'b0;
    if (flush_i) begin
      state_d     = IDLE;
      cnt_d       = CNT_ZERO;
      mat_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_hs_s && (bus.op_i != OP_NOP)) begin
            opcode_d = bus.op_i;
            cnt_d    = CNT_ZERO;
            clr_b_s  = 1'b1;
            state_d  = LOAD_A;
          end else begin
            state_d = IDLE;
          end
        end
        LOAD_A: begin
          if (elem_hs_s) begin
            wr_a_s = 1'b1;
            if (last_s) begin
              cnt_d = CNT_ZERO;
              if (skips_b(opcode_q)) begin
                state_d     = PRESENT;
                mat_valid_d = 1'b1;
              end else begin
                state_d = LOAD_B;
              end
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            state_d = LOAD_A;
          end
        end
        LOAD_B: begin
          if (elem_hs_s) begin
            wr_b_s = 1'b1;
            if (last_s) begin
              cnt_d       = CNT_ZERO;
              state_d     = PRESENT;
              mat_valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            state_d = LOAD_B;
          end
        end
        PRESENT: begin
          if (bus.mat_ready_i) begin
            state_d     = IDLE;
            mat_valid_d = 1'b0;
          end else begin
            state_d = PRESENT;
          end
        end
        default: begin
          state_d     = IDLE;
          cnt_d       = CNT_ZERO;
          mat_valid_d = 1'b0;
        end
      endcase
    end
    op_ready_d   = (state_d == IDLE);
    elem_ready_d = (state_d == LOAD_A) || (state_d == LOAD_B);
  end

  // FSM state, counter and registered handshake outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= CNT_ZERO;
      opcode_q     <= 4'h0;
      mat_valid_q  <= 1'b0;
      op_ready_q   <= 1'b1;
      elem_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      opcode_q     <= opcode_d;
      mat_valid_q  <= mat_valid_d;
      op_ready_q   <= op_ready_d;
      elem_ready_q <= elem_ready_d;
    end
  end

  matrix_shift_fill #(.ELEM_W(ELEM_W), .DIM(DIM)) u_fill_a (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (1'b0),
    .wr_en_i (wr_a_s),
    .bcast_i (1'b0),
    .idx_i   (cnt_q),
    .data_i  (bus.elem_i),
    .mat_o   (bus.matrix_a_o)
  );

  matrix_shift_fill #(.ELEM_W(ELEM_W), .DIM(DIM)) u_fill_b (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr_b_s),
    .wr_en_i (wr_b_s),
    .bcast_i (bcast_s),
    .idx_i   (cnt_q),
    .data_i  (bus.elem_i),
    .mat_o   (bus.matrix_b_o)
  );

  assign bus.op_ready_o   = op_ready_q;
  assign bus.elem_ready_o = elem_ready_q;
  assign bus.mat_valid_o  = mat_valid_q;
  assign bus.opcode_o     = opcode_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed self-checking bench for matrix_loader; expectations are hand-derived
// and follow MLOAD_SCALAR_BCAST_EN when the op-2 broadcast is built in.
module tb_matrix_loader;
  import matrix_pkg::*;

  localparam int EW = ELEM_W_DEF;
  localparam int MW = MAT_W_DEF;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks   = 0;
  int   failures = 0;

  logic [MW-1:0] exp_a;
  logic [MW-1:0] exp_b;

  matrix_loader_if #(.ELEM_W(EW), .DIM(DIM_DEF)) bus ();

  matrix_loader #(.ELEM_W(EW), .DIM(DIM_DEF)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_op(input logic [3:0] op);
    int waited;
    waited = 0;
    @(negedge clk);
    while (bus.op_ready_o !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("op_ready_wait", MW'(bus.op_ready_o), MW'(1'b1));
    bus.op_valid_i = 1'b1;
    bus.op_i       = op;
    @(posedge clk);
    #1;
    bus.op_valid_i = 1'b0;
  endtask

  task automatic send_elem(input logic [15:0] v, input logic fl);
    int waited;
    waited = 0;
    @(negedge clk);
    while (bus.elem_ready_o !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited != 0) chk("elem_ready_wait", MW'(bus.elem_ready_o), MW'(1'b1));
    bus.elem_valid_i = 1'b1;
    bus.elem_i       = v;
    flush            = fl;
    @(posedge clk);
    #1;
    bus.elem_valid_i = 1'b0;
    flush            = 1'b0;
  endtask

  task automatic consume();
    @(negedge clk);
    bus.mat_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.mat_ready_i = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    bus.op_valid_i = 1'b0;
    bus.op_i = 4'h0;
    bus.elem_valid_i = 1'b0;
    bus.elem_i = 16'h0;
    bus.mat_ready_i = 1'b0;
    exp_a = '0;
    exp_b = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_op_ready", MW'(bus.op_ready_o), MW'(1'b1));
    chk("rst_elem_ready", MW'(bus.elem_ready_o), MW'(1'b0));
    chk("rst_mat_valid", MW'(bus.mat_valid_o), MW'(1'b0));
    chk("rst_a", bus.matrix_a_o, exp_a);
    chk("rst_b", bus.matrix_b_o, exp_b);
    chk("rst_opcode", MW'(bus.opcode_o), MW'(4'h0));
    @(negedge clk);
    rst = 1'b1;

    // op 4: A = 1..16, B = 16..1 back to back
    send_op(OP_ADD);
    chk("add_opcode", MW'(bus.opcode_o), MW'(4'h4));
    chk("add_elem_ready", MW'(bus.elem_ready_o), MW'(1'b1));
    chk("add_op_ready", MW'(bus.op_ready_o), MW'(1'b0));
    for (int n = 0; n < 16; n++) begin
      send_elem(16'(n + 1), 1'b0);
      exp_a[n*EW +: EW] = 16'(n + 1);
    end
    chk("add_a_done_valid", MW'(bus.mat_valid_o), MW'(1'b0));
    chk("add_in_load_b", MW'(bus.elem_ready_o), MW'(1'b1));
    for (int n = 0; n < 15; n++) begin
      send_elem(16'(16 - n), 1'b0);
      exp_b[n*EW +: EW] = 16'(16 - n);
    end
    chk("add_31_valid", MW'(bus.mat_valid_o), MW'(1'b0));
    send_elem(16'd1, 1'b0);
    exp_b[15*EW +: EW] = 16'd1;
    chk("add_32_valid", MW'(bus.mat_valid_o), MW'(1'b1));
    chk("add_a_lo", MW'(bus.matrix_a_o[15:0]), MW'(16'd1));
    chk("add_a_hi", MW'(bus.matrix_a_o[255:240]), MW'(16'd16));
    chk("add_b_lo", MW'(bus.matrix_b_o[15:0]), MW'(16'd16));
    chk("add_a_full", bus.matrix_a_o, exp_a);
    chk("add_b_full", bus.matrix_b_o, exp_b);

    // PRESENT held for 10 cycles without mat_ready_i
    repeat (10) begin
      @(negedge clk);
      chk("hold_valid", MW'(bus.mat_valid_o), MW'(1'b1));
      chk("hold_a", bus.matrix_a_o, exp_a);
      chk("hold_b", bus.matrix_b_o, exp_b);
      chk("hold_opcode", MW'(bus.opcode_o), MW'(4'h4));
      chk("hold_elem_ready", MW'(bus.elem_ready_o), MW'(1'b0));
    end
    consume();
    chk("cons_valid", MW'(bus.mat_valid_o), MW'(1'b0));
    chk("cons_op_ready", MW'(bus.op_ready_o), MW'(1'b1));

    // op 5: A only, B cleared by the op handshake
    send_op(OP_TRANS);
    exp_b = '0;
    for (int n = 0; n < 16; n++) send_elem(16'(n + 1), 1'b0);
    chk("trans_valid", MW'(bus.mat_valid_o), MW'(1'b1));
    chk("trans_b_zero", bus.matrix_b_o, exp_b);
    chk("trans_a", bus.matrix_a_o, exp_a);
    chk("trans_opcode", MW'(bus.opcode_o), MW'(4'h5));
    chk("trans_elem_ready", MW'(bus.elem_ready_o), MW'(1'b0));
    @(negedge clk);
    chk("trans_elem_ready2", MW'(bus.elem_ready_o), MW'(1'b0));
    consume();

    // op 2: scalar B
    send_op(OP_SCALE);
    for (int n = 0; n < 16; n++) send_elem(16'(n + 1), 1'b0);
    send_elem(16'h0003, 1'b0);
    for (int n = 0; n < 16; n++) exp_b[n*EW +: EW] = 16'h0003;
`ifdef MLOAD_SCALAR_BCAST_EN
    chk("scale_valid_17", MW'(bus.mat_valid_o), MW'(1'b1));
    chk("scale_b_bcast", bus.matrix_b_o, exp_b);
`else
    chk("scale_valid_17", MW'(bus.mat_valid_o), MW'(1'b0));
    chk("scale_b_slot0", bus.matrix_b_o, MW'(16'h0003));
    for (int n = 1; n < 16; n++) send_elem(16'h0003, 1'b0);
    chk("scale_valid_32", MW'(bus.mat_valid_o), MW'(1'b1));
    chk("scale_b_full", bus.matrix_b_o, exp_b);
`endif
    chk("scale_a", bus.matrix_a_o, exp_a);
    consume();

    // flush on element 7 of A, coinciding with its handshake
    send_op(OP_ADD);
    for (int n = 0; n < 7; n++) begin
      send_elem(16'h0100 + 16'(n), 1'b0);
      exp_a[n*EW +: EW] = 16'h0100 + 16'(n);
    end
    send_elem(16'h0BAD, 1'b1);
    chk("flush_op_ready", MW'(bus.op_ready_o), MW'(1'b1));
    chk("flush_elem_ready", MW'(bus.elem_ready_o), MW'(1'b0));
    chk("flush_valid", MW'(bus.mat_valid_o), MW'(1'b0));
    chk("flush_a_unwritten", bus.matrix_a_o, exp_a);
    send_op(OP_SUB);
    chk("post_flush_opcode", MW'(bus.opcode_o), MW'(4'h3));
    send_elem(16'h00A0, 1'b0);
    exp_a[15:0] = 16'h00A0;
    chk("post_flush_idx0", bus.matrix_a_o, exp_a);
    for (int n = 1; n < 16; n++) begin
      send_elem(16'h00A0 + 16'(n), 1'b0);
      exp_a[n*EW +: EW] = 16'h00A0 + 16'(n);
    end
    chk("post_flush_a", bus.matrix_a_o, exp_a);
    chk("post_flush_load_b", MW'(bus.elem_ready_o), MW'(1'b1));
    chk("post_flush_valid", MW'(bus.mat_valid_o), MW'(1'b0));
    exp_b = '0;
    for (int n = 0; n < 3; n++) begin
      send_elem(16'h00B0 + 16'(n), 1'b0);
      exp_b[n*EW +: EW] = 16'h00B0 + 16'(n);
    end
    chk("partial_b", bus.matrix_b_o, exp_b);

    // reset asserted mid LOAD_B
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_op_ready", MW'(bus.op_ready_o), MW'(1'b1));
    chk("midrst_elem_ready", MW'(bus.elem_ready_o), MW'(1'b0));
    chk("midrst_valid", MW'(bus.mat_valid_o), MW'(1'b0));
    chk("midrst_a", bus.matrix_a_o, MW'(1'b0));
    chk("midrst_b", bus.matrix_b_o, MW'(1'b0));
    chk("midrst_opcode", MW'(bus.opcode_o), MW'(4'h0));
    @(negedge clk);
    rst = 1'b1;

    // op 0 after reset: no load, no operand set
    send_op(OP_NOP);
    repeat (5) begin
      @(negedge clk);
      chk("nop_valid", MW'(bus.mat_valid_o), MW'(1'b0));
      chk("nop_op_ready", MW'(bus.op_ready_o), MW'(1'b1));
      chk("nop_elem_ready", MW'(bus.elem_ready_o), MW'(1'b0));
      chk("nop_opcode", MW'(bus.opcode_o), MW'(4'h0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
